// File: rtl/ahb_lite_decoder_mux.sv
// AHB-Lite 1-master-to-N-slave address decoder and response multiplexer.
// Includes an internal default slave that answers unmapped transfers with a two-cycle ERROR.
module ahb_lite_decoder_mux #(
  parameter int                       ADDR_W   = 32,
  parameter int                       DATA_W   = 32,
  parameter int                       HRESP_W  = 2,
  parameter int                       NUM_S    = 4,
  parameter logic [NUM_S*ADDR_W-1:0]  S_BASE   = '0,
  parameter logic [NUM_S*ADDR_W-1:0]  S_MASK   = '0,
  parameter int                       ERRCNT_W = 16,
  localparam int                      IDX_W    = $clog2(NUM_S + 1)
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [ADDR_W-1:0]         HADDR,
  input  logic [1:0]                HTRANS,
  output logic [NUM_S-1:0]          s_HSEL,
  input  logic [NUM_S-1:0]          s_HREADYOUT,
  input  logic [NUM_S*HRESP_W-1:0]  s_HRESP,
  input  logic [NUM_S*DATA_W-1:0]   s_HRDATA,
  output logic                      HREADY,
  output logic [HRESP_W-1:0]        HRESP,
  output logic [DATA_W-1:0]         HRDATA,
  output logic [IDX_W-1:0]          dsel_idx,
  output logic [ERRCNT_W-1:0]       err_cnt
);

  localparam logic [IDX_W-1:0]   DEF_IDX    = IDX_W'(NUM_S);
  localparam logic [1:0]         DS_OKAY    = 2'd0;
  localparam logic [1:0]         DS_ERR1    = 2'd1;
  localparam logic [1:0]         DS_ERR2    = 2'd2;
  localparam logic [HRESP_W-1:0] RESP_OKAY  = HRESP_W'(0);
  localparam logic [HRESP_W-1:0] RESP_ERROR = HRESP_W'(1);

  logic [NUM_S-1:0]    hit_s;
  logic [NUM_S-1:0]    hsel_s;
  logic [IDX_W-1:0]    sel_idx_s;
  logic                unmapped_s;
  logic                err_start_s;
  logic                hready_s;
  logic [HRESP_W-1:0]  hresp_s;
  logic [DATA_W-1:0]   hrdata_s;
  logic [IDX_W-1:0]    dsel_q, dsel_d;
  logic [1:0]          ds_state_q, ds_state_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  // A zero mask disables a slave outright, so it can never claim an address.
  always_comb begin
    hit_s = '0;
    for (int i = 0; i < NUM_S; i++) begin
      hit_s[i] = ((HADDR & S_MASK[i*ADDR_W +: ADDR_W]) ==
                  (S_BASE[i*ADDR_W +: ADDR_W] & S_MASK[i*ADDR_W +: ADDR_W])) &&
                 (S_MASK[i*ADDR_W +: ADDR_W] != '0);
    end
  end

  // Scanning from the top down lets the lowest-index hit win on overlap.
  always_comb begin
    sel_idx_s = DEF_IDX;
    for (int i = NUM_S - 1; i >= 0; i--) begin
      sel_idx_s = hit_s[i] ? IDX_W'(i) : sel_idx_s;
    end
    hsel_s = '0;
    for (int i = 0; i < NUM_S; i++) begin
      hsel_s[i] = (sel_idx_s == IDX_W'(i));
    end
    unmapped_s = (sel_idx_s == DEF_IDX);
  end

  always_comb begin
    hready_s = 1'b1;
    hresp_s  = RESP_OKAY;
    hrdata_s = '0;
    if (dsel_q == DEF_IDX) begin
      hready_s = (ds_state_q != DS_ERR1);
      hresp_s  = (ds_state_q == DS_OKAY) ? RESP_OKAY : RESP_ERROR;
    end else begin
      for (int i = 0; i < NUM_S; i++) begin
        hready_s = (dsel_q == IDX_W'(i)) ? s_HREADYOUT[i] : hready_s;
        hresp_s  = (dsel_q == IDX_W'(i)) ? s_HRESP[i*HRESP_W +: HRESP_W] : hresp_s;
        hrdata_s = (dsel_q == IDX_W'(i)) ? s_HRDATA[i*DATA_W +: DATA_W] : hrdata_s;
      end
    end
  end

  // Only NONSEQ/SEQ to an unmapped address starts an ERROR response; IDLE/BUSY get OKAY.
  always_comb begin
    err_start_s = hready_s && unmapped_s && (HTRANS inside {2'b10, 2'b11});
    ds_state_d  = ds_state_q;
    case (ds_state_q)
      DS_OKAY: ds_state_d = err_start_s ? DS_ERR1 : DS_OKAY;
      DS_ERR1: ds_state_d = DS_ERR2;
      DS_ERR2: ds_state_d = err_start_s ? DS_ERR1 : DS_OKAY;
      default: ds_state_d = DS_OKAY;
    endcase
    err_cnt_d = err_cnt_q;
    if ((ds_state_d == DS_ERR1) && (ds_state_q != DS_ERR1) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
    dsel_d = hready_s ? sel_idx_s : dsel_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q     <= DEF_IDX;
      ds_state_q <= DS_OKAY;
      err_cnt_q  <= '0;
    end else begin
      dsel_q     <= dsel_d;
      ds_state_q <= ds_state_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign s_HSEL   = hsel_s;
  assign HREADY   = hready_s;
  assign HRESP    = hresp_s;
  assign HRDATA   = hrdata_s;
  assign dsel_idx = dsel_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// Self-checking bench: two decoder configurations share one master/slave stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_ahb_lite_decoder_mux;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic [3:0]   s_ready;
  logic [7:0]   s_resp;
  logic [127:0] s_rdata;

  logic [3:0]   o_hsel   [2];
  logic         o_hready [2];
  logic [1:0]   o_hresp  [2];
  logic [31:0]  o_hrdata [2];
  logic [2:0]   o_dsel   [2];
  logic [15:0]  o_err_a;
  logic [1:0]   o_err_b;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_decoder_mux #(
    .NUM_S(4),
    .S_BASE({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .S_MASK({32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
    .ERRCNT_W(16)
  ) u_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .s_HSEL(o_hsel[0]), .s_HREADYOUT(s_ready), .s_HRESP(s_resp), .s_HRDATA(s_rdata),
    .HREADY(o_hready[0]), .HRESP(o_hresp[0]), .HRDATA(o_hrdata[0]),
    .dsel_idx(o_dsel[0]), .err_cnt(o_err_a)
  );

  // Overlapping slaves 0/1, disabled slave 2, narrow saturating counter.
  ahb_lite_decoder_mux #(
    .NUM_S(4),
    .S_BASE({32'h3000_0000, 32'h0000_0000, 32'h0000_1000, 32'h0000_0000}),
    .S_MASK({32'hF000_0000, 32'h0000_0000, 32'hFFFF_F000, 32'hF000_0000}),
    .ERRCNT_W(2)
  ) u_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .s_HSEL(o_hsel[1]), .s_HREADYOUT(s_ready), .s_HRESP(s_resp), .s_HRDATA(s_rdata),
    .HREADY(o_hready[1]), .HRESP(o_hresp[1]), .HRDATA(o_hrdata[1]),
    .dsel_idx(o_dsel[1]), .err_cnt(o_err_b)
  );

  // Reference model: address map as tables, data-phase owner, and the position
  // inside an ERROR response (0 none, 1 first cycle, 2 second cycle).
  logic [31:0] cfg_base [2][4];
  logic [31:0] cfg_mask [2][4];
  int          m_dsel [2];
  int          m_err  [2];
  int          m_cnt  [2];
  int          m_cap  [2];
  int          e_sel    [2];
  logic        e_hready [2];
  logic [1:0]  e_hresp  [2];
  logic [31:0] e_hrdata [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_dsel[k] = 4;
      m_err[k]  = 0;
      m_cnt[k]  = 0;
    end
  endtask

  task automatic model_eval(input int k);
    e_sel[k] = 4;
    for (int i = 3; i >= 0; i--) begin
      if (cfg_mask[k][i] != 32'h0 &&
          ((HADDR & cfg_mask[k][i]) == (cfg_base[k][i] & cfg_mask[k][i])))
        e_sel[k] = i;
    end
    if (m_dsel[k] < 4) begin
      e_hready[k] = s_ready[m_dsel[k]];
      e_hresp[k]  = s_resp[m_dsel[k]*2 +: 2];
      e_hrdata[k] = s_rdata[m_dsel[k]*32 +: 32];
    end else begin
      e_hready[k] = (m_err[k] != 1);
      e_hresp[k]  = (m_err[k] != 0) ? 2'd1 : 2'd0;
      e_hrdata[k] = 32'h0;
    end
  endtask

  task automatic model_update(input int k);
    if (m_err[k] == 1) begin
      m_err[k] = 2;
    end else if (e_hready[k] && e_sel[k] == 4 && HTRANS[1]) begin
      m_err[k] = 1;
      if (m_cnt[k] < m_cap[k]) m_cnt[k]++;
    end else begin
      m_err[k] = 0;
    end
    if (e_hready[k]) m_dsel[k] = e_sel[k];
  endtask

  task automatic eval_and_check();
    logic [3:0]  eh;
    logic [15:0] oe;
    @(negedge HCLK);
    for (int k = 0; k < 2; k++) begin
      model_eval(k);
      eh = (e_sel[k] < 4) ? (4'b0001 << e_sel[k]) : 4'b0000;
      oe = (k == 0) ? o_err_a : {14'h0, o_err_b};
      check($sformatf("hsel%0d", k),   o_hsel[k],   eh);
      check($sformatf("hready%0d", k), o_hready[k], e_hready[k]);
      check($sformatf("hresp%0d", k),  o_hresp[k],  e_hresp[k]);
      check($sformatf("hrdata%0d", k), o_hrdata[k], e_hrdata[k]);
      check($sformatf("dsel%0d", k),   o_dsel[k],   m_dsel[k]);
      check($sformatf("errcnt%0d", k), oe,          m_cnt[k]);
    end
  endtask

  task automatic advance();
    @(posedge HCLK);
    for (int k = 0; k < 2; k++) model_update(k);
    #1;
  endtask

  task automatic step_cycle();
    eval_and_check();
    advance();
  endtask

  initial begin
    int pre;
    cfg_base[0] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
    cfg_mask[0] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
    cfg_base[1] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_0000, 32'h3000_0000};
    cfg_mask[1] = '{32'hF000_0000, 32'hFFFF_F000, 32'h0000_0000, 32'hF000_0000};
    m_cap[0] = 65535;
    m_cap[1] = 3;

    HRESETn = 1'b0;
    HADDR   = 32'h0;
    HTRANS  = 2'b00;
    s_ready = 4'hF;
    s_resp  = 8'h00;
    s_rdata = {32'h3333_3333, 32'hCAFE_F00D, 32'h1111_1111, 32'h0000_0000};
    model_reset();
    @(posedge HCLK); #1;
    eval_and_check();
    check("rst_hready", o_hready[0], 1'b1);
    check("rst_hresp",  o_hresp[0],  2'd0);
    check("rst_hrdata", o_hrdata[0], 32'h0);
    check("rst_dsel",   o_dsel[0],   3'd4);
    check("rst_errcnt", o_err_a,     16'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Zero-wait routing to slave 2.
    HADDR = 32'h2000_0010; HTRANS = 2'b10;
    eval_and_check();
    check("zw_hsel", o_hsel[0], 4'b0100);
    advance();
    HADDR = 32'h0; HTRANS = 2'b00;
    eval_and_check();
    check("zw_dsel",   o_dsel[0],   3'd2);
    check("zw_hrdata", o_hrdata[0], 32'hCAFE_F00D);
    check("zw_hready", o_hready[0], 1'b1);
    advance();
    step_cycle();

    // Slave 1 stalls three cycles while the master presents a slave-3 address.
    HADDR = 32'h1000_0000; HTRANS = 2'b10;
    step_cycle();
    s_ready[1] = 1'b0; HADDR = 32'h3000_0000;
    for (int c = 0; c < 3; c++) begin
      eval_and_check();
      check("stall_hready", o_hready[0], 1'b0);
      check("stall_dsel",   o_dsel[0],   3'd1);
      advance();
    end
    s_ready[1] = 1'b1;
    eval_and_check();
    check("stall_rel_dsel", o_dsel[0], 3'd1);
    advance();
    HADDR = 32'h0; HTRANS = 2'b00;
    eval_and_check();
    check("stall_new_dsel", o_dsel[0], 3'd3);
    advance();
    step_cycle();
    step_cycle();

    // Unmapped NONSEQ gets the two-cycle ERROR; unmapped IDLE gets OKAY.
    HADDR = 32'h8000_0000; HTRANS = 2'b10;
    pre = m_cnt[0];
    step_cycle();
    HADDR = 32'h0; HTRANS = 2'b00;
    eval_and_check();
    check("unm_c1_hready", o_hready[0], 1'b0);
    check("unm_c1_hresp",  o_hresp[0],  2'd1);
    check("unm_c1_hrdata", o_hrdata[0], 32'h0);
    check("unm_c1_errcnt", o_err_a,     16'(pre + 1));
    advance();
    eval_and_check();
    check("unm_c2_hready", o_hready[0], 1'b1);
    check("unm_c2_hresp",  o_hresp[0],  2'd1);
    advance();
    HADDR = 32'h8000_0000; HTRANS = 2'b00;
    pre = m_cnt[0];
    step_cycle();
    HADDR = 32'h0;
    eval_and_check();
    check("idle_unm_hready", o_hready[0], 1'b1);
    check("idle_unm_hresp",  o_hresp[0],  2'd0);
    check("idle_unm_errcnt", o_err_a,     16'(pre));
    advance();

    // Overlapping decode resolves to the lowest index.
    HADDR = 32'h0000_1000; HTRANS = 2'b00;
    eval_and_check();
    check("ovl_hsel", o_hsel[1], 4'b0001);
    advance();
    HADDR = 32'h0;
    step_cycle();
    step_cycle();

    // Asynchronous reset while the default slave is in its first ERROR cycle.
    HADDR = 32'h8000_0000; HTRANS = 2'b10;
    step_cycle();
    HADDR = 32'h0; HTRANS = 2'b00;
    #1;
    check("ar_pre_hready", o_hready[0], 1'b0);
    HRESETn = 1'b0;
    #1;
    check("ar_hready", o_hready[0], 1'b1);
    check("ar_hresp",  o_hresp[0],  2'd0);
    check("ar_dsel",   o_dsel[0],   3'd4);
    check("ar_errcnt", o_err_a,     16'd0);
    check("ar_b_hready", o_hready[1], 1'b1);
    check("ar_b_errcnt", o_err_b,     2'd0);
    model_reset();
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    step_cycle();

    // Five back-to-back unmapped SEQ transfers: ERR1/ERR2 pairs, counter saturation on u_b.
    for (int c = 0; c <= 10; c++) begin
      HADDR  = 32'h8000_0000 + 32'(4 * c);
      HTRANS = (c <= 8) ? 2'b11 : 2'b00;
      eval_and_check();
      if (c >= 1) begin
        check("b2b_hready", o_hready[0], (c % 2) == 0);
        check("b2b_hresp",  o_hresp[0],  2'd1);
      end
      if (c == 6) check("b2b_errcnt3", o_err_a, 16'd3);
      advance();
    end
    HADDR = 32'h0; HTRANS = 2'b00;
    eval_and_check();
    check("b2b_end_hresp", o_hresp[0], 2'd0);
    check("b2b_errcnt5",   o_err_a,    16'd5);
    check("sat_errcnt",    o_err_b,    2'd3);
    advance();

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0: HADDR = 32'h0000_1000;
        1: HADDR = 32'h0000_0040;
        2: HADDR = 32'h1000_0004;
        3: HADDR = 32'h2000_0010;
        4: HADDR = 32'h3000_0008;
        5: HADDR = 32'h8000_0000;
        6: HADDR = 32'hF000_0000;
        default: HADDR = $urandom;
      endcase
      HTRANS = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) s_ready[i] = ($urandom_range(0, 4) != 0);
      s_resp  = 8'($urandom);
      s_rdata = {$urandom, $urandom, $urandom, $urandom};
      step_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_lite_decoder_mux.md
Name: ahb_lite_decoder_mux

Overview:
Parametrised 1-master-to-N-slave AHB-Lite address decoder and response multiplexer. It is the successor to the single-slave hookup, where HREADY=HREADYOUT, and generalises it to NUM_S slaves plus an internal default slave. It drives per-slave HSEL in the address phase and tracks the data-phase owner. It muxes HREADYOUT/HRESP/HRDATA back to the master as global HREADY, and generates the two-cycle ERROR response for unmapped accesses.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (8..1024, power of 2)
HRESP_W, 2, response width; only encodings OKAY=0 and ERROR=1 are generated internally
NUM_S, 4, number of external slaves (1..16)
S_BASE, {NUM_S*ADDR_W}'0, flattened per-slave base addresses; slave i occupies bits [i*ADDR_W +: ADDR_W]
S_MASK, {NUM_S*ADDR_W}'0, flattened per-slave decode masks; a mask of all-zero disables the slave
ERRCNT_W, 16, width of the unmapped-error counter

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
HADDR  in  ADDR_W  master address
HTRANS  in  2  master transfer type
s_HSEL  out  NUM_S  per-slave select, address phase
s_HREADYOUT  in  NUM_S  per-slave ready
s_HRESP  in  NUM_S*HRESP_W  per-slave response, flattened
s_HRDATA  in  NUM_S*DATA_W  per-slave read data, flattened
HREADY  out  1  global ready to the master; also fanned out to every slave
HRESP  out  HRESP_W  muxed response
HRDATA  out  DATA_W  muxed read data
dsel_idx  out  $clog2(NUM_S+1)  current data-phase owner; value NUM_S = default slave
err_cnt  out  ERRCNT_W  saturating count of unmapped NONSEQ/SEQ transfers accepted

Behaviour:
- Decode (combinational):
  - hit_i = ((HADDR & MASK_i) == (BASE_i & MASK_i)) && (MASK_i != 0).
  - Overlapping hits resolve to the lowest index.
  - s_HSEL is one-hot or zero and is independent of HTRANS, per AHB.
  - No hit selects the default slave (index NUM_S).
- Data-phase owner register dsel:
  - Loads the address-phase selection on any HCLK edge with HREADY=1.
  - Holds while HREADY=0.
  - Reset value: NUM_S.
- Output mux (combinational from dsel):
  - HREADY, HRESP and HRDATA come from the selected slave.
  - Default slave: HRDATA=0; HREADY and HRESP come from its FSM.
- Default-slave FSM, states DS_OKAY, DS_ERR1, DS_ERR2:
  - DS_OKAY: HREADYOUT=1, HRESP=OKAY.
    - Transition to DS_ERR1 when HREADY=1, the address phase is unmapped and HTRANS[1]=1 (NONSEQ/SEQ).
    - An unmapped IDLE(00) or BUSY(01) gets a zero-wait OKAY and stays in DS_OKAY.
  - DS_ERR1: HREADYOUT=0, HRESP=ERROR. Always goes to DS_ERR2.
  - DS_ERR2: HREADYOUT=1, HRESP=ERROR. HREADY=1 here, so the next address phase is sampled this cycle.
    - Back-to-back unmapped NONSEQ/SEQ goes to DS_ERR1.
    - Anything else goes to DS_OKAY.
  - The FSM only influences outputs while dsel=NUM_S.
  - Reset state: DS_OKAY.
- Error counter err_cnt:
  - Increments by 1 on each DS_OKAY/DS_ERR2 -> DS_ERR1 transition.
  - Saturates at all-ones with no wrap.
  - Reset value 0.
- Reset values (HRESETn=0, asynchronous):
  - dsel=NUM_S, FSM=DS_OKAY, err_cnt=0.
  - Therefore HREADY=1, HRESP=OKAY, HRDATA=0, dsel_idx=NUM_S.
  - s_HSEL still follows HADDR combinationally.
- Reset mid-transfer: a stalled slave or a pending ERROR is abandoned immediately. The first cycle after release behaves as reset state.
- Slave stalls: a slave holding HREADYOUT=0 freezes dsel, so address-phase HSEL changes by the master are ignored until HREADY=1.
- Slave ERROR responses pass through unmodified. The two-cycle ERROR protocol is the slave's responsibility.
- NUM_S=1 must elaborate; dsel_idx width is then 1.
- No latency is added: there are no register stages on the data path.

Test Plan:
- Zero-wait routing: NUM_S=4, BASE0=0x0000_0000/MASK=0xF000_0000 … BASE3=0x3000_0000. Master issues NONSEQ read at 0x2000_0010 with s_HRDATA[2]=0xCAFE_F00D. Required: s_HSEL=4'b0100 in the address phase; next cycle dsel_idx=2, HRDATA=0xCAFE_F00D, HREADY=1.
- Wait-state stall: slave1 holds HREADYOUT=0 for 3 cycles while the master presents an address to slave3. Required: HREADY=0 for 3 cycles, dsel_idx stays 1, then becomes 3 one cycle after HREADY returns to 1.
- Unmapped error: NONSEQ at 0x8000_0000. Required in the data phase: cycle 1 HREADY=0/HRESP=1, cycle 2 HREADY=1/HRESP=1, HRDATA=0, err_cnt 0->1. An unmapped IDLE produces OKAY with no wait and err_cnt unchanged.
- Back-to-back errors: three consecutive unmapped SEQ transfers. Required: three ERR1/ERR2 pairs with no OKAY gap and err_cnt=3. With ERRCNT_W=2 and five errors, err_cnt saturates at 3.
- Overlap priority: BASE0 and BASE1 both match 0x0000_1000. Required: s_HSEL=4'b0001.
- Async reset during DS_ERR1: assert HRESETn=0 mid-cycle. Required: HREADY=1, HRESP=0, dsel_idx=NUM_S and err_cnt=0 without waiting for an HCLK edge.
